uart_cmd_controller: RTL and testbench

//   Sequences the CoreUART instance in uart_reader: drains RX bytes, parses 4-byte command

---
 rtl/uart_cmd_controller.sv | 151 +++++++++++++++
 tb/tb_uart_cmd_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
// Command-frame sequencer for the CoreUART wrapper: SYNC/CMD/ADDR/DATA frames drive a small register bank (reg0[3:0] -> LEDs).
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_controller #(
  parameter int         NUM_REGS    = 4,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxrdy,
  input  logic [7:0] rx_data,
  input  logic       parity_err,
  input  logic       framing_err,
  input  logic       overflow,
  output logic       oen,
  input  logic       txrdy,
  output logic [7:0] tx_data,
  output logic       wen,
  output logic [3:0] led,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic       ovf_seen
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  if (NUM_REGS < 1 || NUM_REGS > 16 || TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("uart_cmd_controller: bad parameter set");
  end

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, EXEC, SEND, SEND_WAIT} state_t;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  state_t     state;
  frame_t     frm;
  logic [7:0] resp;
  logic [7:0] regs [NUM_REGS];
  logic       rd_guard;
  logic [1:0] wait_cnt;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  logic          take, byte_err, addr_ok;
  logic [AW-1:0] idx;

  // A byte is consumed only once per rxrdy assertion; rd_guard waits for rxrdy to drop.
  assign take     = rxrdy && !rd_guard && (state inside {IDLE, GET_CMD, GET_ADDR, GET_DATA});
  assign byte_err = parity_err | framing_err;
  assign addr_ok  = frm.addr < 8'(NUM_REGS);
  assign idx      = frm.addr[AW-1:0];
  assign led      = regs[0][3:0];
  assign busy     = (state != IDLE);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      frm      <= '0;
      resp     <= '0;
      rd_guard <= 1'b0;
      wait_cnt <= '0;
      oen      <= 1'b1;
      wen      <= 1'b1;
      tx_data  <= '0;
      err_cnt  <= '0;
      ovf_seen <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      oen      <= 1'b1;
      wen      <= 1'b1;
      ovf_seen <= ovf_seen | overflow;
      if (!rxrdy) rd_guard <= 1'b0;

      if (take) begin
        oen      <= 1'b0;
        rd_guard <= 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
        tmo_cnt  <= '0;
`endif
        if (state == IDLE) begin
          if (!byte_err && rx_data == SYNC_BYTE) state <= GET_CMD;
        end else if (byte_err) begin
          resp    <= NAK;
          err_cnt <= sat_inc(err_cnt);
          state   <= SEND;
        end else begin
          case (state)
            GET_CMD:  begin frm.cmd  <= rx_data; state <= GET_ADDR; end
            GET_ADDR: begin frm.addr <= rx_data; state <= GET_DATA; end
            GET_DATA: begin frm.data <= rx_data; state <= EXEC;     end
            default: ;
          endcase
        end
      end else begin
        case (state)
`ifdef UART_CMD_TIMEOUT_EN
          GET_CMD, GET_ADDR, GET_DATA: begin
            if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
              state   <= IDLE;
              err_cnt <= sat_inc(err_cnt);
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`endif
          EXEC: begin
            if (frm.cmd == CMD_WR && addr_ok) begin
              regs[idx] <= frm.data;
              resp      <= ACK;
            end else if (frm.cmd == CMD_RD && addr_ok) begin
              resp <= regs[idx];
            end else begin
              resp    <= NAK;
              err_cnt <= sat_inc(err_cnt);
            end
            state <= SEND;
          end
          SEND: begin
            if (txrdy) begin
              tx_data  <= resp;
              wen      <= 1'b0;
              wait_cnt <= '0;
              state    <= SEND_WAIT;
            end
          end
          // Leave once the UART has taken the byte, or after 4 cycles regardless.
          SEND_WAIT: begin
            if (!txrdy || wait_cnt == 2'd3) state <= IDLE;
            else wait_cnt <= wait_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: a CoreUART behavioural model feeds RX bytes and checks TX responses.
module tb_uart_cmd_controller;
  localparam int NREG = 4;
  localparam int TMO  = 40;

  logic       clk = 1'b0, rst = 1'b0;
  logic       rxrdy = 1'b0, parity_err = 1'b0, framing_err = 1'b0, overflow = 1'b0, txrdy = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       oen, wen, busy, ovf_seen;
  logic [7:0] tx_data, err_cnt;
  logic [3:0] led;

  int n_checks = 0, n_fail = 0;
  int wen_pulses = 0, oen_pulses = 0, tx_busy = 0;
  bit tx_hold = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_err = 8'h00;
  logic [7:0] model [NREG];

  uart_cmd_controller #(.NUM_REGS(NREG), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rxrdy(rxrdy), .rx_data(rx_data), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow), .oen(oen), .txrdy(txrdy), .tx_data(tx_data),
    .wen(wen), .led(led), .busy(busy), .err_cnt(err_cnt), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  // TX side of the UART model: scoreboard pop on each wen-low cycle, then txrdy drops for 3 cycles.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!oen) oen_pulses++;
      if (!wen) begin
        wen_pulses++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: tx_data=%h with no response expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_fail++;
            $display("FAIL tx_data: got %h expected %h", tx_data, e);
          end
        end
        tx_busy = 3;
      end else if (tx_busy > 0) tx_busy--;
      txrdy = !tx_hold && (tx_busy == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit pe = 1'b0, input bit fe = 1'b0, input int hold = 0);
    int n = 0;
    rx_data = b; parity_err = pe; framing_err = fe; rxrdy = 1'b1;
    while (oen !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL rx_read_timeout: byte %h never read (oen=%b)", b, oen);
    end
    repeat (hold) @(negedge clk);
    rxrdy = 1'b0; parity_err = 1'b0; framing_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hA5); send_byte(c); send_byte(a); send_byte(d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b pending=%0d expected busy=0 pending=0", tag, busy, exp_q.size());
    end
  endtask

  task automatic check_err(input string tag);
    n_checks++;
    if (err_cnt !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err_cnt: got %h expected %h", tag, err_cnt, exp_err);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if (oen !== 1'b1 || wen !== 1'b1 || tx_data !== 8'h00 || led !== 4'h0 ||
        busy !== 1'b0 || err_cnt !== 8'h00 || ovf_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: oen=%b wen=%b tx=%h led=%h busy=%b err=%h ovf=%b expected 1 1 00 0 0 00 0",
               tag, oen, wen, tx_data, led, busy, err_cnt, ovf_seen);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("after_release");
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
  endtask

  task automatic test_write();
    int n = 0;
    int wp = wen_pulses;
    exp_q.push_back(8'h06);
    model[0] = 8'h0F;
    do_frame(8'h57, 8'h00, 8'h0F);
    while (wen !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL write_latency: wen low %0d negedges after last byte, expected 1 (3 cycles from capture)", n);
    end
    wait_idle("write");
    n_checks++;
    if (led !== 4'hF) begin n_fail++; $display("FAIL write_led: got %h expected f", led); end
    n_checks++;
    if (wen_pulses - wp != 1) begin
      n_fail++; $display("FAIL write_wen_count: got %0d expected 1", wen_pulses - wp);
    end
    check_err("write");
  endtask

  task automatic test_read();
    exp_q.push_back(8'h0F);
    do_frame(8'h52, 8'h00, 8'hFF);
    wait_idle("read0");
    exp_q.push_back(model[1]);
    do_frame(8'h52, 8'h01, 8'h77);
    wait_idle("read1");
    n_checks++;
    if (led !== 4'hF) begin n_fail++; $display("FAIL read_led: got %h expected f", led); end
    check_err("read");
  endtask

  task automatic test_bad_frames();
    exp_q.push_back(8'h15); exp_err = sat(exp_err);
    do_frame(8'h57, 8'h05, 8'h11);
    wait_idle("bad_addr");
    check_err("bad_addr");
    exp_q.push_back(8'h15); exp_err = sat(exp_err);
    do_frame(8'h99, 8'h00, 8'h22);
    wait_idle("bad_cmd");
    check_err("bad_cmd");
    // addr 5 must not alias onto reg1
    exp_q.push_back(model[1]);
    do_frame(8'h52, 8'h01, 8'h00);
    wait_idle("alias");
    exp_q.push_back(model[0]);
    do_frame(8'h52, 8'h00, 8'h00);
    wait_idle("reg0_kept");
  endtask

  task automatic test_rx_errors();
    int op = oen_pulses;
    int wp = wen_pulses;
    exp_q.push_back(8'h15); exp_err = sat(exp_err);
    send_byte(8'h33, 1'b0, 1'b0, 3);
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h01, 1'b1);
    wait_idle("parity_abort");
    check_err("parity_abort");
    n_checks++;
    if (oen_pulses - op != 4) begin
      n_fail++; $display("FAIL oen_pulse_count: got %0d expected 4", oen_pulses - op);
    end
    exp_q.push_back(8'h15); exp_err = sat(exp_err);
    send_byte(8'hA5); send_byte(8'h52, 1'b0, 1'b1);
    wait_idle("framing_abort");
    check_err("framing_abort");
    // a corrupted SYNC keeps us in IDLE, so the rest of the frame is dropped too
    send_byte(8'hA5, 1'b1); send_byte(8'h57); send_byte(8'h00); send_byte(8'h03);
    repeat (8) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wen_pulses - wp != 2 || led !== 4'hF) begin
      n_fail++;
      $display("FAIL bad_sync_dropped: busy=%b wen_pulses=%0d led=%h expected 0 2 f", busy, wen_pulses - wp, led);
    end
    check_err("bad_sync");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    n_checks++;
    if (ovf_seen !== 1'b0) begin n_fail++; $display("FAIL ovf_initial: got %b expected 0", ovf_seen); end
    for (int i = 0; i < NREG; i++) begin
      v = 8'($urandom_range(0, 255));
      model[i] = v;
      exp_q.push_back(8'h06);
      send_byte(8'hA5); send_byte(8'h57);
      if (i == 2) begin overflow = 1'b1; @(negedge clk); overflow = 1'b0; end
      send_byte(8'(i)); send_byte(v);
    end
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back(model[i]);
      do_frame(8'h52, 8'(i), 8'h5A);
    end
    wait_idle("b2b");
    n_checks++;
    if (ovf_seen !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf_seen); end
    n_checks++;
    if (led !== model[0][3:0]) begin n_fail++; $display("FAIL b2b_led: got %h expected %h", led, model[0][3:0]); end
    check_err("b2b");
  endtask

  task automatic test_timeout();
    int wp = wen_pulses;
    send_byte(8'hA5); send_byte(8'h57);
`ifdef UART_CMD_TIMEOUT_EN
    repeat (TMO + 2) @(negedge clk);
    exp_err = sat(exp_err);
    n_checks++;
    if (busy !== 1'b0 || wen_pulses != wp) begin
      n_fail++; $display("FAIL timeout: busy=%b wen_pulses=%0d expected 0 0", busy, wen_pulses - wp);
    end
    check_err("timeout");
`else
    repeat (TMO + 60) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || wen_pulses != wp) begin
      n_fail++; $display("FAIL no_timeout_wait: busy=%b wen_pulses=%0d expected 1 0", busy, wen_pulses - wp);
    end
    model[0] = 8'h03;
    exp_q.push_back(8'h06);
    send_byte(8'h00); send_byte(8'h03);
    wait_idle("no_timeout");
    n_checks++;
    if (led !== 4'h3) begin n_fail++; $display("FAIL no_timeout_led: got %h expected 3", led); end
    check_err("no_timeout");
`endif
  endtask

  task automatic test_err_saturate();
    while (exp_err != 8'hFF) begin
      exp_q.push_back(8'h15); exp_err = sat(exp_err);
      do_frame(8'h00, 8'h00, 8'h00);
      wait_idle("sat_fill");
    end
    check_err("sat_reach");
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h15);
      do_frame(8'h57, 8'hF0, 8'h00);
      wait_idle("sat_hold");
    end
    check_err("sat_hold");
  endtask

  task automatic test_reset_mid();
    int wp;
    send_byte(8'hA5); send_byte(8'h57); send_byte(8'h00);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_frame_busy: got %b expected 1", busy); end
    rst = 1'b0; #1;
    check_reset_vals("reset_get_data");
    @(negedge clk); rst = 1'b1; @(negedge clk);
    exp_err = 8'h00;
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    wp = wen_pulses;
    send_byte(8'h0F);
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wen_pulses != wp || led !== 4'h0) begin
      n_fail++; $display("FAIL partial_discarded: busy=%b wen=%0d led=%h expected 0 0 0", busy, wen_pulses - wp, led);
    end
    tx_hold = 1'b1;
    @(negedge clk);
    do_frame(8'h57, 8'h00, 8'h0A);
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || wen !== 1'b1 || led !== 4'hA) begin
      n_fail++; $display("FAIL send_stall: busy=%b wen=%b led=%h expected 1 1 a", busy, wen, led);
    end
    rst = 1'b0; #1;
    check_reset_vals("reset_in_send");
    @(negedge clk); rst = 1'b1; tx_hold = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wen_pulses != wp) begin n_fail++; $display("FAIL send_dropped: wen pulses %0d expected 0", wen_pulses - wp); end
    exp_q.push_back(8'h00);
    do_frame(8'h52, 8'h00, 8'h00);
    wait_idle("post_reset_read");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_frames();
    test_rx_errors();
    test_back_to_back();
    test_timeout();
    test_err_saturate();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
